// File: rtl/lbs_req_arb_if.sv
// Request-side and peripheral register-bus signals of the lbs_req_arb arbiter.
// slave modport: the arbiter; master modport: requesters plus the peripheral bus.
interface lbs_req_arb_if #(
  parameter int unsigned REQ_NUMS = 4
);
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned CSW = 16;

  logic [REQ_NUMS-1:0]    req;
  logic [REQ_NUMS-1:0]    req_wr;
  logic [AW*REQ_NUMS-1:0] req_addr;
  logic [DW*REQ_NUMS-1:0] req_wdata;
  logic [REQ_NUMS-1:0]    ack;
  logic [DW-1:0]          rdata;
  logic                   busy;
  logic [AW-1:0]          lbs_addr;
  logic [DW-1:0]          lbs_din;
  logic [DW-1:0]          lbs_dout;
  logic                   lbs_we;
  logic                   lbs_re;
  logic [CSW-1:0]         lbs_cs_n;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, lbs_dout,
    output ack, rdata, busy, lbs_addr, lbs_din, lbs_we, lbs_re, lbs_cs_n
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, lbs_dout,
    input  ack, rdata, busy, lbs_addr, lbs_din, lbs_we, lbs_re, lbs_cs_n
  );
endinterface

// File: rtl/lbs_req_arb.sv
// Round-robin arbiter/sequencer for the shared 8-bit peripheral register bus.
// Optional LBS_ARB_PRIO0_EN: requester 0 gets fixed top priority, 1..REQ_NUMS-1 rotate.
module lbs_req_arb #(
  parameter int unsigned REQ_NUMS = 4,
  parameter int unsigned RD_LAT   = 2
) (
  input logic          clk,
  input logic          rst,
  lbs_req_arb_if.slave bus
);

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 8;
  localparam int unsigned PW  = 4;
  localparam int unsigned CSW = 16;
  localparam int unsigned GW  = (REQ_NUMS > 1) ? $clog2(REQ_NUMS) : 1;
  localparam int unsigned CW  = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [REQ_NUMS-1:0] ack_q, ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       din_q, din_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic [CSW-1:0]      cs_n_q, cs_n_d;

  logic                pick_vld;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       cand;
  logic [AW-1:0]       pick_addr;

  // Winner search: first requesting index after the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
`ifdef LBS_ARB_PRIO0_EN
    if (bus.req[0]) begin
      pick_vld = 1'b1;
    end else begin
      for (int i = 1; i < int'(REQ_NUMS); i++) begin
        cand = GW'((int'(ptr_q) - 1 + i) % (int'(REQ_NUMS) - 1) + 1);
        if (!pick_vld && bus.req[cand]) begin
          pick_vld = 1'b1;
          pick     = cand;
        end
      end
    end
`else
    for (int i = 1; i <= int'(REQ_NUMS); i++) begin
      cand = GW'((int'(ptr_q) + i) % int'(REQ_NUMS));
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
`endif
  end

  assign pick_addr = bus.req_addr[int'(pick)*AW +: AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(REQ_NUMS - 1);
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      re_q    <= re_d;
      cs_n_q  <= cs_n_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    cs_n_d  = cs_n_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_SETUP;
          gnt_d   = pick;
          wr_d    = bus.req_wr[pick];
          addr_d  = pick_addr;
          din_d   = bus.req_wdata[int'(pick)*DW +: DW];
          busy_d  = 1'b1;
          cs_n_d  = ~(CSW'(1) << pick_addr[AW-1 -: PW]);
`ifdef LBS_ARB_PRIO0_EN
          if (pick != '0) ptr_d = pick;
`else
          ptr_d = pick;
`endif
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        we_d    = wr_q;
        re_d    = ~wr_q;
      end
      S_ACCESS: begin
        cnt_d = '0;
        if (wr_q) begin
          state_d      = S_DONE;
          ack_d[gnt_q] = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d      = S_DONE;
          rdata_d      = bus.lbs_dout;
          ack_d[gnt_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = '1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.lbs_addr = addr_q;
  assign bus.lbs_din  = din_q;
  assign bus.lbs_we   = we_q;
  assign bus.lbs_re   = re_q;
  assign bus.lbs_cs_n = cs_n_q;

endmodule

// File: tb/tb_lbs_req_arb.sv
// Directed bench for lbs_req_arb (REQ_NUMS=4, RD_LAT=2); expectations follow LBS_ARB_PRIO0_EN.
module tb_lbs_req_arb;

  localparam int unsigned REQ_NUMS = 4;
  localparam int unsigned RD_LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  int   seq3[5];
  int   seq6[4];

  lbs_req_arb_if #(.REQ_NUMS(REQ_NUMS)) ifc ();

  lbs_req_arb #(.REQ_NUMS(REQ_NUMS), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic post(input int idx, input logic wr, input logic [11:0] addr, input logic [7:0] data);
    ifc.req_wr[idx]            = wr;
    ifc.req_addr[idx*12 +: 12] = addr;
    ifc.req_wdata[idx*8 +: 8]  = data;
    ifc.req[idx]               = 1'b1;
  endtask

  task automatic wait_ack();
    int w = 0;
    while (ifc.ack == '0 && w < 12) begin
      tick();
      w++;
    end
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_ack"},   32'(ifc.ack),      32'h0);
    chk({pfx, "_rdata"}, 32'(ifc.rdata),    32'h0);
    chk({pfx, "_busy"},  32'(ifc.busy),     32'h0);
    chk({pfx, "_addr"},  32'(ifc.lbs_addr), 32'h0);
    chk({pfx, "_din"},   32'(ifc.lbs_din),  32'h0);
    chk({pfx, "_we"},    32'(ifc.lbs_we),   32'h0);
    chk({pfx, "_re"},    32'(ifc.lbs_re),   32'h0);
    chk({pfx, "_cs_n"},  32'(ifc.lbs_cs_n), 32'hFFFF);
  endtask

  initial begin
`ifdef LBS_ARB_PRIO0_EN
    seq3 = '{0, 0, 0, 0, 0};
    seq6 = '{0, 0, 0, 0};
`else
    seq3 = '{0, 1, 2, 3, 0};
    seq6 = '{1, 2, 3, 0};
`endif
    rst           = 1'b1;
    ifc.req       = '0;
    ifc.req_wr    = '0;
    ifc.req_addr  = '0;
    ifc.req_wdata = '0;
    ifc.lbs_dout  = 8'h3C;
    tick();
    tick();
    chk_rst("reset");
    rst = 1'b0;

    // single write from requester 1
    post(1, 1'b1, 12'h305, 8'hA5);
    tick();
    chk("t1_cs_n",     32'(ifc.lbs_cs_n), 32'hFFF7);
    chk("t1_addr",     32'(ifc.lbs_addr), 32'h305);
    chk("t1_din",      32'(ifc.lbs_din),  32'hA5);
    chk("t1_we_setup", 32'(ifc.lbs_we),   32'h0);
    chk("t1_busy",     32'(ifc.busy),     32'h1);
    tick();
    chk("t1_we",       32'(ifc.lbs_we),   32'h1);
    chk("t1_re",       32'(ifc.lbs_re),   32'h0);
    chk("t1_ack_early", 32'(ifc.ack),     32'h0);
    tick();
    chk("t1_ack",      32'(ifc.ack),      32'h2);
    chk("t1_we_done",  32'(ifc.lbs_we),   32'h0);
    chk("t1_busy_done", 32'(ifc.busy),    32'h1);
    ifc.req[1] = 1'b0;
    tick();
    chk("t1_ack_pulse", 32'(ifc.ack),     32'h0);
    chk("t1_cs_idle",  32'(ifc.lbs_cs_n), 32'hFFFF);
    chk("t1_busy_idle", 32'(ifc.busy),    32'h0);

    // single read from requester 2, RD_LAT=2
    post(2, 1'b0, 12'h810, 8'h00);
    tick();
    chk("t2_cs_n",     32'(ifc.lbs_cs_n), 32'hFEFF);
    tick();
    chk("t2_re",       32'(ifc.lbs_re),   32'h1);
    chk("t2_we",       32'(ifc.lbs_we),   32'h0);
    tick();
    chk("t2_re_drop",  32'(ifc.lbs_re),   32'h0);
    chk("t2_ack_w1",   32'(ifc.ack),      32'h0);
    tick();
    chk("t2_ack_w2",   32'(ifc.ack),      32'h0);
    tick();
    chk("t2_ack",      32'(ifc.ack),      32'h4);
    chk("t2_rdata",    32'(ifc.rdata),    32'h3C);
    ifc.req[2]   = 1'b0;
    ifc.lbs_dout = 8'h77;
    tick();
    chk("t2_rdata_hold", 32'(ifc.rdata),  32'h3C);

    // a write must leave rdata alone
    post(0, 1'b1, 12'h0AA, 8'hEE);
    wait_ack();
    chk("wr_ack",      32'(ifc.ack),      32'h1);
    ifc.req[0] = 1'b0;
    tick();
    chk("wr_rdata_keep", 32'(ifc.rdata),  32'h3C);

    // all four held after a reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) post(i, 1'b1, 12'(i * 256 + 16), 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      wait_ack();
      chk($sformatf("t3_ack%0d", k), 32'(ifc.ack), 32'(1) << seq3[k]);
      if (k == 4) ifc.req = '0;
      tick();
      chk($sformatf("t3_pulse%0d", k), 32'(ifc.ack), 32'h0);
    end

    // reset in the middle of a read wait
    post(2, 1'b0, 12'h123, 8'h00);
    tick();
    tick();
    tick();
    chk("t4_wait_busy", 32'(ifc.busy),    32'h1);
    rst     = 1'b1;
    ifc.req = '0;
    tick();
    chk_rst("t4_reset");
    rst = 1'b0;
    tick();
    tick();
    chk("t4_no_ack",   32'(ifc.ack),      32'h0);
    post(0, 1'b1, 12'h0C0, 8'h01);
    post(2, 1'b1, 12'h2C0, 8'h02);
    tick();
    chk("t4_first_addr", 32'(ifc.lbs_addr), 32'h0C0);
    wait_ack();
    chk("t4_ack0",     32'(ifc.ack),      32'h1);
    ifc.req[0] = 1'b0;
    tick();
    wait_ack();
    chk("t4_ack2",     32'(ifc.ack),      32'h4);
    ifc.req[2] = 1'b0;
    tick();

    // req[3] dropped after grant; req[0] arrives mid-transaction
    post(3, 1'b1, 12'hA40, 8'h5A);
    tick();
    ifc.req[3] = 1'b0;
    chk("t5_addr",     32'(ifc.lbs_addr), 32'hA40);
    chk("t5_cs_n",     32'(ifc.lbs_cs_n), 32'hFBFF);
    tick();
    chk("t5_we",       32'(ifc.lbs_we),   32'h1);
    chk("t5_din",      32'(ifc.lbs_din),  32'h5A);
    post(0, 1'b1, 12'h0F0, 8'h11);
    tick();
    chk("t5_ack3",     32'(ifc.ack),      32'h8);
    tick();
    chk("t5_idle_ack", 32'(ifc.ack),      32'h0);
    chk("t5_idle_busy", 32'(ifc.busy),    32'h0);
    chk("t5_idle_cs",  32'(ifc.lbs_cs_n), 32'hFFFF);
    tick();
    chk("t5_addr0",    32'(ifc.lbs_addr), 32'h0F0);
    chk("t5_cs0",      32'(ifc.lbs_cs_n), 32'hFFFE);
    tick();
    chk("t5_din0",     32'(ifc.lbs_din),  32'h11);
    tick();
    chk("t5_ack0",     32'(ifc.ack),      32'h1);
    ifc.req[0] = 1'b0;
    tick();

    // req 1..3 held, req[0] re-raised every IDLE
    for (int i = 0; i < 4; i++) post(i, 1'b1, 12'(i * 256 + 32), 8'(8'h20 + i));
    for (int k = 0; k < 4; k++) begin
      wait_ack();
      chk($sformatf("t6_ack%0d", k), 32'(ifc.ack), 32'(1) << seq6[k]);
      ifc.req[0] = 1'b0;
      if (k == 3) ifc.req = '0;
      tick();
      chk($sformatf("t6_pulse%0d", k), 32'(ifc.ack), 32'h0);
      if (k < 3) ifc.req[0] = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
